// File: rtl/path_request_sequencer.sv
// Front-end controller for the shortest-path engine. It accepts one route
// request, launches the engine from the start node and walks the engine's
// previous-node table back from the end node onto a LIFO. It then streams the
// route start->end to the motion logic. Bad requests raise a one-cycle err.
module path_request_sequencer #(
  parameter int N_NODES = 13,
  parameter int NODE_W  = 4,
  parameter int DIST_W  = 8,
  parameter int INF     = 99
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NODE_W-1:0] req_start,
  input  logic [NODE_W-1:0] req_end,
  output logic              eng_start,
  output logic [NODE_W-1:0] eng_src,
  input  logic              eng_done,
  output logic [NODE_W-1:0] rd_addr,
  input  logic [DIST_W-1:0] rd_dist,
  input  logic [NODE_W-1:0] rd_prev,
  output logic              path_valid,
  input  logic              path_ready,
  output logic [NODE_W-1:0] path_node,
  output logic              path_last,
  output logic [DIST_W-1:0] path_cost,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(N_NODES + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_NODES);
  localparam logic [CNT_W-1:0]  CNT_GUARD = CNT_W'(N_NODES - 1);
  localparam logic [DIST_W-1:0] DIST_INF  = DIST_W'(INF);
  localparam logic [DIST_W-1:0] DIST_ZERO = DIST_W'(0);
  localparam logic [NODE_W-1:0] NODE_ZERO = NODE_W'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RD     = 3'd3,
    S_CHK    = 3'd4,
    S_EMIT   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // Node id is inside the graph.
  function automatic logic id_valid(input logic [NODE_W-1:0] id);
    return (32'(id) < 32'(N_NODES));
  endfunction

  state_e              state_q, state_d;
  logic [NODE_W-1:0]   src_q, src_d;
  logic [NODE_W-1:0]   dst_q, dst_d;
  logic [NODE_W-1:0]   cur_q, cur_d;
  logic                first_q, first_d;
  logic [NODE_W-1:0]   stack_q [N_NODES];
  logic [NODE_W-1:0]   stack_d [N_NODES];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    top_idx_s;

  logic                req_ready_q, req_ready_d;
  logic                eng_start_q, eng_start_d;
  logic [NODE_W-1:0]   eng_src_q, eng_src_d;
  logic [NODE_W-1:0]   rd_addr_q, rd_addr_d;
  logic                path_valid_q, path_valid_d;
  logic [NODE_W-1:0]   path_node_q, path_node_d;
  logic                path_last_q, path_last_d;
  logic [DIST_W-1:0]   path_cost_q, path_cost_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  // Next-state, stack and registered-output computation.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cur_d       = cur_q;
    first_d     = first_q;
    stack_d     = stack_q;
    cnt_d       = cnt_q;
    eng_src_d   = eng_src_q;
    rd_addr_d   = rd_addr_q;
    path_cost_d = path_cost_q;
    eng_start_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          src_d       = req_start;
          dst_d       = req_end;
          cnt_d       = CNT_ZERO;
          path_cost_d = DIST_ZERO;
          if (!id_valid(req_start) || !id_valid(req_end)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (req_start == req_end) begin
            // Trivial route: the start node is the whole path.
            stack_d[0] = req_start;
            cnt_d      = CNT_ONE;
            state_d    = S_EMIT;
          end else begin
            eng_start_d = 1'b1;
            eng_src_d   = req_start;
            state_d     = S_LAUNCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LAUNCH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (eng_done) begin
          cur_d     = dst_q;
          rd_addr_d = dst_q;
          first_d   = 1'b1;
          state_d   = S_RD;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_RD: begin
        // Table read is in flight; data arrives next cycle.
        state_d = S_CHK;
      end

      S_CHK: begin
        first_d = 1'b0;
        if (first_q && (rd_dist == DIST_INF)) begin
          cnt_d   = CNT_ZERO;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          if (first_q) begin
            path_cost_d = rd_dist;
          end else begin
            path_cost_d = path_cost_q;
          end
          if (cnt_q < CNT_FULL) begin
            stack_d[cnt_q] = cur_q;
            cnt_d          = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
          if (cur_q == src_q) begin
            state_d = S_EMIT;
          end else if ((cnt_q >= CNT_GUARD) || !id_valid(rd_prev)) begin
            // A route can't visit more nodes than the graph has: a cycle
            // in the previous-node table, or a corrupt link.
            cnt_d   = CNT_ZERO;
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            cur_d     = rd_prev;
            rd_addr_d = rd_prev;
            state_d   = S_RD;
          end
        end
      end

      S_EMIT: begin
        if (path_valid_q && path_ready) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_EMIT;
          end
        end else begin
          state_d = S_EMIT;
        end
      end

      S_ERR: begin
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end

      default: begin
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    top_idx_s    = cnt_d - CNT_ONE;
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    path_valid_d = (state_d == S_EMIT) && (cnt_d != CNT_ZERO);
    if (path_valid_d) begin
      path_node_d = stack_d[top_idx_s];
      path_last_d = (cnt_d == CNT_ONE);
    end else begin
      path_node_d = NODE_ZERO;
      path_last_d = 1'b0;
    end
  end

  // State, stack and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_q        <= NODE_ZERO;
      dst_q        <= NODE_ZERO;
      cur_q        <= NODE_ZERO;
      first_q      <= 1'b0;
      for (int i = 0; i < N_NODES; i++) begin
        stack_q[i] <= NODE_ZERO;
      end
      cnt_q        <= CNT_ZERO;
      req_ready_q  <= 1'b1;
      eng_start_q  <= 1'b0;
      eng_src_q    <= NODE_ZERO;
      rd_addr_q    <= NODE_ZERO;
      path_valid_q <= 1'b0;
      path_node_q  <= NODE_ZERO;
      path_last_q  <= 1'b0;
      path_cost_q  <= DIST_ZERO;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      cur_q        <= cur_d;
      first_q      <= first_d;
      stack_q      <= stack_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      eng_start_q  <= eng_start_d;
      eng_src_q    <= eng_src_d;
      rd_addr_q    <= rd_addr_d;
      path_valid_q <= path_valid_d;
      path_node_q  <= path_node_d;
      path_last_q  <= path_last_d;
      path_cost_q  <= path_cost_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign eng_start  = eng_start_q;
  assign eng_src    = eng_src_q;
  assign rd_addr    = rd_addr_q;
  assign path_valid = path_valid_q;
  assign path_node  = path_node_q;
  assign path_last  = path_last_q;
  assign path_cost  = path_cost_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
